// File: rtl/masked_gf24_mul_pipe_pkg.sv
// -----------------------------------------------------------------------------
// masked_gf24_mul_pipe_pkg
// Purpose : Shared constants and helper functions for the masked GF(2^4)
//           multiplier pipeline.
//           - Index helpers: random-pair count, lexicographic pair index, and
//             bit offsets of share/random nibbles inside the packed buses.
//           - GF(2^2) primitives for the normal-basis tower field.
//
// Field representation (normal-basis tower):
//   GF(2^2): nibble bits [1:0] = coefficients of (W^2, W), where W^2+W+1 = 0.
//            The identity is 2'b11.
//   GF(2^4): nibble bits [3:2] = coefficient of Z^4, bits [1:0] = coefficient
//            of Z, where Z^2+Z+N = 0 and N = W^2 (2'b10).
//            The identity is 4'hF.
// -----------------------------------------------------------------------------
package masked_gf24_mul_pipe_pkg;

  localparam int NIB = 4;

  typedef logic [NIB-1:0] nib_t;
  typedef logic [1:0]     gf4_t;

  // Number of fresh random nibbles needed per lane: one per unordered share pair.
  function automatic int nrnd(input int nshare);
    return nshare * (nshare - 1) / 2;
  endfunction

  // Lexicographic index of the unordered pair {i, j}, i != j.
  // Order is (0,1), (0,2), ..., (1,2), ...
  function automatic int pair_idx(input int i, input int j, input int nshare);
    int a;
    int b;
    a = (i < j) ? i : j;
    b = (i < j) ? j : i;
    return a * nshare - (a * (a + 1)) / 2 + (b - a - 1);
  endfunction

  // Bit offset of share 'share' of lane 'lane' in an x/y/z bus.
  function automatic int share_off(input int lane, input int share, input int nshare);
    return (lane * nshare + share) * NIB;
  endfunction

  // Bit offset of random nibble 'pair' of lane 'lane' in the rnd bus.
  function automatic int rnd_off(input int lane, input int pair, input int nrnd_lane);
    return (lane * nrnd_lane + pair) * NIB;
  endfunction

  // GF(2^2) multiply, normal basis (W^2, W).
  function automatic gf4_t gf4_mul(input gf4_t a, input gf4_t b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction

  // GF(2^2) scale by N = W^2.
  function automatic gf4_t gf4_scl_n(input gf4_t a);
    return {a[0], a[1] ^ a[0]};
  endfunction

endpackage : masked_gf24_mul_pipe_pkg

// File: rtl/masked_gf24_mul_pipe_gf24mul.sv
// -----------------------------------------------------------------------------
// gf24mul
// Purpose : Combinational GF(2^4) multiplier in the normal-basis tower field.
//           It operates on a single share of each operand, so it never
//           combines two shares of the same operand.
// Ports   : in0  - multiplicand nibble
//           in1  - multiplier nibble
//           out0 - product nibble
// -----------------------------------------------------------------------------
module gf24mul
  import masked_gf24_mul_pipe_pkg::*;
(
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  output logic [3:0] out0
);

  gf4_t a_hi;
  gf4_t a_lo;
  gf4_t b_hi;
  gf4_t b_lo;
  gf4_t e;

  assign a_hi = in0[3:2];
  assign a_lo = in0[1:0];
  assign b_hi = in1[3:2];
  assign b_lo = in1[1:0];

  // The cross term N*(a_hi+a_lo)*(b_hi+b_lo) is common to both output halves.
  assign e = gf4_scl_n(gf4_mul(a_hi ^ a_lo, b_hi ^ b_lo));

  assign out0 = {gf4_mul(a_hi, b_hi) ^ e, gf4_mul(a_lo, b_lo) ^ e};

endmodule : gf24mul

// File: rtl/masked_gf24_mul_pipe.sv
// -----------------------------------------------------------------------------
// masked_gf24_mul_pipe
// Purpose : Two-stage, domain-oriented-masking (DOM-indep) GF(2^4) multiplier.
//           It performs LANES independent multiplications per transfer, with
//           NSHARE Boolean shares per operand.
//           - Stage 1 registers every share product x_i*y_j. Each cross
//             product (i != j) is first re-masked with a fresh nibble r_ij.
//           - Stage 2 folds row i into output share z_i.
// Ports   : clk        - clock, all state on rising edge
//           rst        - synchronous active-high reset
//           in_valid   - operand transfer offered
//           in_ready   - operands accepted (with in_valid)
//           x, y       - operand shares, lane l share s at [(l*NSHARE+s)*4 +: 4]
//           rnd        - fresh randomness, lane l pair p at [(l*NRND+p)*4 +: 4]
//           rnd_valid  - rnd holds unused randomness
//           rnd_ready  - rnd consumed (with rnd_valid)
//           out_valid  - z holds product shares
//           out_ready  - downstream accepts z
//           z          - product shares, same packing as x
// -----------------------------------------------------------------------------
module masked_gf24_mul_pipe
  import masked_gf24_mul_pipe_pkg::*;
#(
  parameter int NSHARE = 2,
  parameter int LANES  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*NSHARE*NIB-1:0]   x,
  input  logic [LANES*NSHARE*NIB-1:0]   y,
  input  logic [LANES*nrnd(NSHARE)*NIB-1:0] rnd,
  input  logic                          rnd_valid,
  output logic                          rnd_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*NSHARE*NIB-1:0]   z
);

  localparam int NRND = nrnd(NSHARE);

  // Stage-1 terms indexed [lane][row i][column j]; stage-2 shares [lane][i].
  logic [LANES-1:0][NSHARE-1:0][NSHARE-1:0][NIB-1:0] s1_d;
  logic [LANES-1:0][NSHARE-1:0][NSHARE-1:0][NIB-1:0] s1_q;
  logic [LANES-1:0][NSHARE-1:0][NIB-1:0]             z_d;
  logic [LANES-1:0][NSHARE-1:0][NIB-1:0]             z_q;
  logic                                              s1_valid;
  logic                                              out_valid_q;
  logic                                              adv;
  logic                                              fire;

  // The whole pipeline moves together unless the output is stalled.
  assign adv  = !(out_valid_q && !out_ready);
  assign fire = in_valid && rnd_valid && adv && !rst;

  // Each ready is the ready half of its own handshake and does not wait on
  // that handshake's valid; both are held low during reset.
  assign in_ready  = adv && rnd_valid && !rst;
  assign rnd_ready = adv && in_valid && !rst;

  // ---------------------------------------------------------------------------
  // Share products: one multiplier per (lane, i, j). Cross terms are
  // re-masked before they reach a register. A nibble is shared by (i,j) and
  // (j,i), so it cancels in the unmasked result.
  // ---------------------------------------------------------------------------
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar i = 0; i < NSHARE; i++) begin : g_row
      for (genvar j = 0; j < NSHARE; j++) begin : g_col
        logic [NIB-1:0] prod;

        gf24mul u_mul (
          .in0  (x[share_off(l, i, NSHARE) +: NIB]),
          .in1  (y[share_off(l, j, NSHARE) +: NIB]),
          .out0 (prod)
        );

        if (i == j) begin : g_diag
          assign s1_d[l][i][j] = prod;
        end else begin : g_cross
          assign s1_d[l][i][j] = prod ^ rnd[rnd_off(l, pair_idx(i, j, NSHARE), NRND) +: NIB];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-2 compression: z_i = XOR over j of stage-1 term (i, j).
  // Only registered terms are combined here.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path through this block can infer a latch.
    z_d = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int i = 0; i < NSHARE; i++) begin
        for (int j = 0; j < NSHARE; j++) begin
          z_d[l][i] = z_d[l][i] ^ s1_q[l][i][j];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: data registers are reset as well as valids, so no share
      // material survives a reset; the pipeline is small enough that this is cheap.
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
    end else if (adv) begin
      // NOTE: non-blocking assignments give every register its pre-edge value,
      // so stage 2 captures what stage 1 held before this edge.
      s1_valid    <= fire;
      s1_q        <= fire ? s1_d : '0;  // a bubble flushes stale shares to zero
      out_valid_q <= s1_valid;
      z_q         <= z_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;

endmodule : masked_gf24_mul_pipe
